// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of data_memory: one request in flight, registered
// memory strobes, out-of-range detection and saturating load/store activity counters.
module mem_access_ctrl #(
  parameter int unsigned MEM_AW = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             mem_wrt,
  output logic             mem_read,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data_in,
  input  logic [31:0]      mem_data_out,
  output logic [CNT_W-1:0] load_count,
  output logic [CNT_W-1:0] store_count
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StWait, StResp} state_e;

  // Address bits above the decoded range; all-zero mask when MEM_AW covers the full word.
  localparam logic [31:0] HiMask = ~((32'h1 << MEM_AW) - 32'h1);

  state_e state_q;
  logic   out_of_range;

  assign out_of_range = |(req_addr & HiMask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_wrt     <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      load_count  <= '0;
      store_count <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            mem_address <= req_addr;
            mem_data_in <= req_wdata;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            if (out_of_range) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_wr) begin
              state_q <= StWrite;
              mem_wrt <= 1'b1;
            end else begin
              state_q  <= StRead;
              mem_read <= 1'b1;
            end
          end
        end
        StWrite: begin
          mem_wrt    <= 1'b0;
          resp_valid <= 1'b1;
          state_q    <= StResp;
          if (store_count != '1) store_count <= store_count + 1'b1;
        end
        StRead: begin
          mem_read <= 1'b0;
          state_q  <= StWait;
        end
        StWait: begin
          // data_memory presented the read data on the edge that ended StRead.
          resp_rdata <= mem_data_out;
          resp_valid <= 1'b1;
          state_q    <= StResp;
          if (load_count != '1) load_count <= load_count + 1'b1;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_wrt   <= 1'b0;
          mem_read  <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a word-addressed memory model sits on the
// mem_* side; a second instance with 2-bit counters shares the stimulus.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, mem_wrt, mem_read;
  logic [31:0] resp_rdata, mem_address, mem_data_in, mem_data_out;
  logic [15:0] load_count, store_count;

  logic        req_ready2, resp_valid2, resp_err2, mem_wrt2, mem_read2;
  logic [31:0] resp_rdata2, mem_address2, mem_data_in2;
  logic [1:0]  load_count2, store_count2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_AW(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wrt(mem_wrt), .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .load_count(load_count),
    .store_count(store_count)
  );

  mem_access_ctrl #(.MEM_AW(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid2),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
    .mem_wrt(mem_wrt2), .mem_read(mem_read2), .mem_address(mem_address2),
    .mem_data_in(mem_data_in2), .mem_data_out(mem_data_out), .load_count(load_count2),
    .store_count(store_count2)
  );

  // data_memory model: write and read both take effect on the clock edge.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_wrt) mem[mem_address[7:0]] <= mem_data_in;
    if (mem_read) mem_data_out <= mem[mem_address[7:0]];
  end

  int          cyc = 0;
  int          wrt_cycles = 0, rd_cycles = 0, both_cycles = 0;
  logic [31:0] last_wr_addr, last_wr_data;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (mem_wrt) begin
      wrt_cycles++;
      last_wr_addr = mem_address;
      last_wr_data = mem_data_in;
    end
    if (mem_read) rd_cycles++;
    if (mem_wrt && mem_read) both_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait for its accept edge, then count cycles to resp_valid.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      output int lat);
    int n;
    req_wr = wr; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_valid_after_handshake", 32'(resp_valid), 32'd0);
    check("req_ready_after_handshake", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, w0, r0, a_prev, a_cur, gap_bad, hold_bad;
    logic [31:0] rd_hold;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem_data_out = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    repeat (2) tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_strobes", {30'd0, mem_wrt, mem_read}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_counts", {load_count, store_count}, 32'd0);
    rst = 1'b0;
    tick();
    check("req_ready_after_rst", 32'(req_ready), 32'd1);

    // Store then load at 0x10.
    w0 = wrt_cycles; r0 = rd_cycles;
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat);
    check("store_latency", 32'(lat), 32'd2);
    check("store_wrt_cycles", 32'(wrt_cycles - w0), 32'd1);
    check("store_addr", last_wr_addr, 32'h10);
    check("store_data", last_wr_data, 32'hDEAD_BEEF);
    check("store_resp", {resp_rdata[30:0], resp_err}, 32'd0);
    check("store_count_1", 32'(store_count), 32'd1);
    finish_resp();
    send(1'b0, 32'h0000_0010, 32'h0, lat);
    check("load_latency", 32'(lat), 32'd3);
    check("load_rdata", resp_rdata, 32'hDEAD_BEEF);
    check("load_err", 32'(resp_err), 32'd0);
    check("load_rd_cycles", 32'(rd_cycles - r0), 32'd1);
    check("load_count_1", 32'(load_count), 32'd1);
    finish_resp();

    // Out-of-range load.
    r0 = rd_cycles;
    send(1'b0, 32'h0001_0004, 32'h0, lat);
    check("err_latency", 32'(lat), 32'd1);
    check("err_flag", 32'(resp_err), 32'd1);
    check("err_rdata", resp_rdata, 32'd0);
    check("err_no_read", 32'(rd_cycles - r0), 32'd0);
    check("err_counts", {load_count, store_count}, {16'd1, 16'd1});
    finish_resp();

    // Response backpressure for 5 cycles.
    send(1'b0, 32'h0000_0010, 32'h0, lat);
    rd_hold = resp_rdata;
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!resp_valid || req_ready || resp_rdata !== rd_hold) hold_bad++;
    end
    check("bp_hold", 32'(hold_bad), 32'd0);
    check("bp_rdata", resp_rdata, 32'hDEAD_BEEF);
    finish_resp();

    // Back-to-back stores with req_valid held and resp_ready high.
    w0 = wrt_cycles; r0 = rd_cycles; gap_bad = 0; a_prev = 0;
    resp_ready = 1'b1; req_wr = 1'b1; req_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      int n;
      req_addr = 32'(i); req_wdata = 32'hA000_0000 + 32'(i);
      n = 0;
      while (!req_ready && n < 20) begin tick(); n++; end
      tick();
      a_cur = cyc;
      if (i > 1 && a_cur - a_prev != 3) gap_bad++;
      a_prev = a_cur;
    end
    req_valid = 1'b0;
    repeat (4) tick();
    resp_ready = 1'b0;
    check("b2b_gap", 32'(gap_bad), 32'd0);
    check("b2b_wrt_cycles", 32'(wrt_cycles - w0), 32'd3);
    check("b2b_no_read", 32'(rd_cycles - r0), 32'd0);
    check("b2b_mem3", mem[3], 32'hA000_0003);
    check("b2b_store_count", 32'(store_count), 32'd4);

    // Asynchronous reset during READ.
    req_wr = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rst_mid_read_active", 32'(mem_read), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_mid_read_drop", 32'(mem_read), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_mid_no_resp", 32'(resp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_counts", {load_count, store_count}, 32'd0);

    // Saturation of the 2-bit instance over 5 loads.
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 32'h0000_0020, 32'h0, lat);
      finish_resp();
      if (i == 2) check("sat_after_3", 32'(load_count2), 32'd3);
    end
    check("sat_after_5", 32'(load_count2), 32'd3);
    check("wide_after_5", 32'(load_count), 32'd5);
    check("never_both_strobes", 32'(both_cycles), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
